spsram_arb: RTL

Two-port arbiter and sequencer in front of one `spsram` instance (or the 32-entry banked pair). It clears the whole array after reset, then shares the single SRAM port between two requesters with round-robin arbitration. It issues at most one access per cycle and returns read data to the requester that issued the read, in issue order.

---
 rtl/spsram_arb_if.sv | 50 +++++
 rtl/spsram_arb.sv | 137 +++++++++++++
 2 files changed

// File: rtl/spsram_arb_if.sv
// Bundle of requester handshakes, responses and SRAM port signals for spsram_arb.
`timescale 1ns/1ps
interface spsram_arb_if #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
);
    logic               i_req0_valid;
    logic               o_req0_ready;
    logic               i_req0_we;
    logic [BW_ADDR-1:0] i_req0_addr;
    logic [BW_DATA-1:0] i_req0_wdata;
    logic               i_req1_valid;
    logic               o_req1_ready;
    logic               i_req1_we;
    logic [BW_ADDR-1:0] i_req1_addr;
    logic [BW_DATA-1:0] i_req1_wdata;
    logic               o_rsp0_valid;
    logic [BW_DATA-1:0] o_rsp0_rdata;
    logic               o_rsp1_valid;
    logic [BW_DATA-1:0] o_rsp1_rdata;
    logic               o_sram_cen;
    logic               o_sram_wen;
    logic               o_sram_oen;
    logic [BW_ADDR-1:0] o_sram_addr;
    logic [BW_DATA-1:0] o_sram_data;
    logic [BW_DATA-1:0] i_sram_data;
    logic               o_init_done;

    // Arbiter side
    modport slave (
        input  i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        input  i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata,
        input  i_sram_data,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_valid, o_rsp0_rdata, o_rsp1_valid, o_rsp1_rdata,
        output o_sram_cen, o_sram_wen, o_sram_oen, o_sram_addr, o_sram_data,
        output o_init_done
    );

    // Requester / SRAM environment side
    modport master (
        output i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata,
        output i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata,
        output i_sram_data,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_valid, o_rsp0_rdata, o_rsp1_valid, o_rsp1_rdata,
        input  o_sram_cen, o_sram_wen, o_sram_oen, o_sram_addr, o_sram_data,
        input  o_init_done
    );
endinterface

// File: rtl/spsram_arb.sv
// Clears the SRAM after reset, then round-robin shares its single port between two
// requesters and routes read data back to the issuing requester in order.
`timescale 1ns/1ps
module spsram_arb #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    spsram_arb_if.slave  bus
);
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [BW_ADDR-1:0] cnt_q, cnt_d;
    logic               init_done_q, init_done_d;
    logic               ptr_q, ptr_d;
    logic               grant0, grant1;
    logic               cen_q, cen_d, wen_q, wen_d, oen_q;
    logic [BW_ADDR-1:0] addr_q, addr_d;
    logic [BW_DATA-1:0] data_q, data_d;
    // Read tags are {valid, requester id}
    logic [1:0]         tag1_q, tag1_d, tag2_q;
    logic               rsp0_valid_q, rsp1_valid_q;
    logic [BW_DATA-1:0] rdata0_q, rdata1_q;

    // Next-state, grant and SRAM command selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        cen_d       = 1'b0;
        wen_d       = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        tag1_d      = 2'b00;
        unique case (state_q)
            StInit: begin
                cen_d  = 1'b1;
                wen_d  = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + BW_ADDR'(1);
                if (cnt_q == {BW_ADDR{1'b1}}) begin
                    state_d     = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
                // Pointer only breaks ties; a lone requester is always granted
                grant0 = bus.i_req0_valid && (!bus.i_req1_valid || !ptr_q);
                grant1 = bus.i_req1_valid && (!bus.i_req0_valid ||  ptr_q);
                if (grant0) begin
                    cen_d  = 1'b1;
                    wen_d  = bus.i_req0_we;
                    addr_d = bus.i_req0_addr;
                    data_d = bus.i_req0_wdata;
                    ptr_d  = 1'b1;
                    tag1_d = {!bus.i_req0_we, 1'b0};
                end else if (grant1) begin
                    cen_d  = 1'b1;
                    wen_d  = bus.i_req1_we;
                    addr_d = bus.i_req1_addr;
                    data_d = bus.i_req1_wdata;
                    ptr_d  = 1'b0;
                    tag1_d = {!bus.i_req1_we, 1'b1};
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Control state, SRAM command registers and read-tag pipeline
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            ptr_q       <= 1'b0;
            cen_q       <= 1'b0;
            wen_q       <= 1'b0;
            oen_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            tag1_q      <= 2'b00;
            tag2_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            // Output enable covers the cycle the SRAM drives read data
            oen_q       <= cen_q && !wen_q;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
        end
    end

    // Capture read data for the requester named by the stage-2 tag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rsp0_valid_q <= tag2_q[1] && !tag2_q[0];
            rsp1_valid_q <= tag2_q[1] &&  tag2_q[0];
            if (tag2_q[1] && !tag2_q[0]) begin
                rdata0_q <= bus.i_sram_data;
            end
            if (tag2_q[1] && tag2_q[0]) begin
                rdata1_q <= bus.i_sram_data;
            end
        end
    end

    assign bus.o_req0_ready = grant0;
    assign bus.o_req1_ready = grant1;
    assign bus.o_rsp0_valid = rsp0_valid_q;
    assign bus.o_rsp1_valid = rsp1_valid_q;
    assign bus.o_rsp0_rdata = rdata0_q;
    assign bus.o_rsp1_rdata = rdata1_q;
    assign bus.o_sram_cen   = cen_q;
    assign bus.o_sram_wen   = wen_q;
    assign bus.o_sram_oen   = oen_q;
    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_data  = data_q;
    assign bus.o_init_done  = init_done_q;
endmodule
